mem_io_responder: RTL and testbench

Responder at the far end of the byte-wide RAM bus driven by the CPU memory controller. It serves one byte per cycle from an internal synchronous byte RAM. It decodes the I/O region selected by address bit 17 into a UART-style transmit FIFO, a receive FIFO, a status byte and a simulation-done flag. It sits between the controller's `ram_*` port and the top-level board/testbench I/O pins.

---
 rtl/mem_io_responder.sv | 136 +++++++++++++
 tb/tb_mem_io_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide RAM bus responder: synchronous byte RAM plus an I/O window (addr bit 17)
// holding a TX FIFO, an RX FIFO, a status byte and a sticky simulation-done flag.
module mem_io_responder #(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ram_rw,
  input  logic [31:0] ram_addr,
  input  logic [7:0]  ram_w_data,
  output logic [7:0]  ram_r_data,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready,
  input  logic        io_rx_valid,
  input  logic [7:0]  io_rx_data,
  output logic        io_rx_ready,
  output logic        sim_done,
  output logic        tx_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  logic [7:0] mem    [2**RAM_ADDR_W];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [PtrW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]      r_data_q, r_data_d;
  logic            rd0_q, done_q, ovf_q;

  logic                  io, ram_wr, rd0, wr0, wr4;
  logic [2:0]            off;
  logic [RAM_ADDR_W-1:0] idx;
  logic                  tx_full, tx_nonempty, rx_full, rx_nonempty;
  logic                  tx_push, tx_pop, tx_drop, rx_push, rx_pop;
  logic                  unused_addr;

  assign unused_addr = ^ram_addr;

  assign io     = ram_addr[17];
  assign off    = ram_addr[2:0];
  assign idx    = ram_addr[RAM_ADDR_W-1:0];
  assign ram_wr = ram_rw && !io;
  assign rd0    = !ram_rw && io && (off == 3'd0);
  assign wr0    = ram_rw && io && (off == 3'd0);
  assign wr4    = ram_rw && io && (off == 3'd4);

  assign tx_full     = (tx_cnt_q == CntFull);
  assign tx_nonempty = (tx_cnt_q != '0);
  assign rx_full     = (rx_cnt_q == CntFull);
  assign rx_nonempty = (rx_cnt_q != '0);

  // A full TX FIFO still accepts a push when the sink drains in the same cycle.
  assign tx_pop  = tx_nonempty && io_tx_ready;
  assign tx_push = wr0 && (!tx_full || tx_pop);
  assign tx_drop = wr0 && tx_full && !tx_pop;
  assign rx_push = io_rx_valid && !rx_full;
  // Only the first cycle of a run of offset-0 reads consumes an RX byte.
  assign rx_pop  = rd0 && !rd0_q && rx_nonempty;

  assign io_tx_valid = tx_nonempty;
  assign io_tx_data  = tx_nonempty ? tx_mem[tx_rd_q] : 8'h00;
  assign io_rx_ready = !rx_full;
  assign ram_r_data  = r_data_q;
  assign sim_done    = done_q;
  assign tx_overflow = ovf_q;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CntW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CntW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    rx_cnt_d = rx_cnt_q;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CntW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CntW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_comb begin
    r_data_d = 8'h00;
    if (!io) begin
      r_data_d = ram_rw ? ram_w_data : mem[idx];
    end else if (!ram_rw) begin
      if (off == 3'd0) begin
        r_data_d = rx_nonempty ? rx_mem[rx_rd_q] : 8'h00;
      end else if (off == 3'd4) begin
        r_data_d = {5'b0, ovf_q, tx_full, rx_nonempty};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      r_data_q <= 8'h00;
      rd0_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      r_data_q <= r_data_d;
      rd0_q    <= rd0;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      if (tx_push) tx_wr_q <= tx_wr_q + PtrW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrW'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + PtrW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrW'(1);
      if (tx_drop) ovf_q  <= 1'b1;
      if (wr4)     done_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; writes are suppressed during reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (ram_wr)  mem[idx]         <= ram_w_data;
      if (tx_push) tx_mem[tx_wr_q]  <= ram_w_data;
      if (rx_push) rx_mem[rx_wr_q]  <= io_rx_data;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed vector table, randomized traffic against a
// queue-based reference model, and an ordered TX stream through pointer wrap-around.
module tb_mem_io_responder;

  localparam int D = 16;
  localparam logic [31:0] IDLE = 32'h0003_0001;
  localparam logic [31:0] ST   = 32'h0003_0004;
  localparam logic [31:0] D0   = 32'h0003_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ram_rw = 1'b0;
  logic [31:0] ram_addr = IDLE;
  logic [7:0]  ram_w_data = 8'h00;
  logic [7:0]  ram_r_data;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready = 1'b0;
  logic        io_rx_valid = 1'b0;
  logic [7:0]  io_rx_data = 8'h00;
  logic        io_rx_ready;
  logic        sim_done;
  logic        tx_overflow;

  int vectors = 0;
  int miscompares = 0;

  mem_io_responder #(.RAM_ADDR_W(17), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data), .io_tx_valid(io_tx_valid),
    .io_tx_data(io_tx_data), .io_tx_ready(io_tx_ready), .io_rx_valid(io_rx_valid),
    .io_rx_data(io_rx_data), .io_rx_ready(io_rx_ready), .sim_done(sim_done),
    .tx_overflow(tx_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit rw; logic [31:0] addr; logic [7:0] wd; bit txr; bit rxv; logic [7:0] rxd;
    bit chk_rd; logic [7:0] e_rd; bit e_txv; logic [7:0] e_txd; bit e_done; bit e_ovf;
  } vec_t;
  vec_t vq[$];

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] memm [8];
  bit m_ovf, m_done, m_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit rst, input bit rw, input logic [31:0] addr, input logic [7:0] wd,
                     input bit txr, input bit rxv, input logic [7:0] rxd, input bit chk_rd,
                     input logic [7:0] e_rd, input bit e_txv, input logic [7:0] e_txd,
                     input bit e_done, input bit e_ovf);
    vec_t v;
    v = '{rst, rw, addr, wd, txr, rxv, rxd, chk_rd, e_rd, e_txv, e_txd, e_done, e_ovf};
    vq.push_back(v);
  endtask

  task automatic drive(input bit rst, input bit rw, input logic [31:0] addr, input logic [7:0] wd,
                       input bit txr, input bit rxv, input logic [7:0] rxd);
    reset = rst; ram_rw = rw; ram_addr = addr; ram_w_data = wd;
    io_tx_ready = txr; io_rx_valid = rxv; io_rx_data = rxd;
  endtask

  // Predicts ram_r_data for this cycle and advances the model past the clock edge.
  task automatic model_cycle(input bit rst, input bit rw, input logic [31:0] addr,
                             input logic [7:0] wd, input bit txr, input bit rxv,
                             input logic [7:0] rxd, output logic [7:0] exp_rd);
    bit io, rd0, txpop, rxpop, rxpush;
    logic [2:0] off;
    if (rst) begin
      txq.delete(); rxq.delete(); m_ovf = 0; m_done = 0; m_prev = 0; exp_rd = 8'h00;
      return;
    end
    io = addr[17];
    off = addr[2:0];
    if (!io) exp_rd = rw ? wd : memm[addr[2:0]];
    else if (rw) exp_rd = 8'h00;
    else if (off == 3'd0) exp_rd = (rxq.size() > 0) ? rxq[0] : 8'h00;
    else if (off == 3'd4) exp_rd = {5'b0, m_ovf, txq.size() == D, rxq.size() != 0};
    else exp_rd = 8'h00;
    rd0 = io && !rw && off == 3'd0;
    txpop = txq.size() > 0 && txr;
    rxpop = rd0 && !m_prev && rxq.size() > 0;
    rxpush = rxv && rxq.size() < D;
    if (!io && rw) memm[addr[2:0]] = wd;
    if (txpop) void'(txq.pop_front());
    if (io && rw && off == 3'd0) begin
      if (txq.size() < D) txq.push_back(wd);
      else m_ovf = 1;
    end
    if (io && rw && off == 3'd4) m_done = 1;
    if (rxpop) void'(rxq.pop_front());
    if (rxpush) rxq.push_back(rxd);
    m_prev = rd0;
  endtask

  task automatic step(input bit rst, input bit rw, input logic [31:0] addr, input logic [7:0] wd,
                      input bit txr, input bit rxv, input logic [7:0] rxd);
    logic [7:0] exp_rd;
    drive(rst, rw, addr, wd, txr, rxv, rxd);
    model_cycle(rst, rw, addr, wd, txr, rxv, rxd, exp_rd);
    @(posedge clock);
    #1;
    chk("rnd rdata", 32'(ram_r_data), 32'(exp_rd));
    chk("rnd tx_valid", 32'(io_tx_valid), 32'(txq.size() > 0));
    chk("rnd tx_data", 32'(io_tx_data), (txq.size() > 0) ? 32'(txq[0]) : 32'h0);
    chk("rnd rx_ready", 32'(io_rx_ready), 32'(rxq.size() < D));
    chk("rnd sim_done", 32'(sim_done), 32'(m_done));
    chk("rnd tx_overflow", 32'(tx_overflow), 32'(m_ovf));
  endtask

  initial begin
    logic [31:0] addr, prev_addr;
    logic [7:0]  in_q[$];
    logic [7:0]  out_q[$];
    bit          prev_rw, txr;
    int          pct, op, cyc;

    // Directed table
    add(1, 0, IDLE, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 32'h10, 8'hA5, 0, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0, 0);
    add(0, 0, 32'h10, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0, 0);
    add(0, 1, 32'h11, 8'h3C, 0, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 0, 0);
    add(0, 0, 32'h10, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0, 0);
    add(0, 0, 32'h40011, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 0, 0);
    add(0, 0, IDLE, 8'h00, 0, 1, 8'h7E, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, ST, 8'h00, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0, 0);
    add(0, 0, D0, 8'h00, 0, 0, 8'h00, 1, 8'h7E, 0, 8'h00, 0, 0);
    add(0, 0, D0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, ST, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, D0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, IDLE, 8'h00, 0, 1, 8'h11, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, IDLE, 8'h00, 0, 1, 8'h22, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, D0, 8'h00, 0, 0, 8'h00, 1, 8'h11, 0, 8'h00, 0, 0);
    add(0, 0, D0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, D0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, ST, 8'h00, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0, 0);
    add(0, 0, D0, 8'h00, 0, 0, 8'h00, 1, 8'h22, 0, 8'h00, 0, 0);
    add(0, 0, ST, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, D0, 8'h48, 0, 0, 8'h00, 1, 8'h00, 1, 8'h48, 0, 0);
    add(0, 1, D0, 8'h69, 0, 0, 8'h00, 1, 8'h00, 1, 8'h48, 0, 0);
    add(0, 0, IDLE, 8'h00, 1, 0, 8'h00, 1, 8'h00, 1, 8'h69, 0, 0);
    add(0, 0, IDLE, 8'h00, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 0; i <= D; i++)
      add(0, 1, D0, 8'(8'h10 + i), 0, 0, 8'h00, 1, 8'h00, 1, 8'h10, 0, i == D);
    add(0, 0, ST, 8'h00, 0, 0, 8'h00, 1, 8'h06, 1, 8'h10, 0, 1);
    for (int k = 1; k <= D; k++)
      add(0, 0, IDLE, 8'h00, 1, 0, 8'h00, 1, 8'h00, k < D, (k < D) ? 8'(8'h10 + k) : 8'h00, 0, 1);
    add(0, 1, ST, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++)
      add(0, 1, D0, 8'(8'hC0 + i), 0, 0, 8'h00, 1, 8'h00, 1, 8'hC0, 1, 1);
    add(1, 1, D0, 8'hEE, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, ST, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].rw, vq[i].addr, vq[i].wd, vq[i].txr, vq[i].rxv, vq[i].rxd);
      @(posedge clock);
      #1;
      if (vq[i].chk_rd) chk($sformatf("row%0d rdata", i), 32'(ram_r_data), 32'(vq[i].e_rd));
      chk($sformatf("row%0d tx_valid", i), 32'(io_tx_valid), 32'(vq[i].e_txv));
      chk($sformatf("row%0d tx_data", i), 32'(io_tx_data), 32'(vq[i].e_txd));
      chk($sformatf("row%0d rx_ready", i), 32'(io_rx_ready), 32'h1);
      chk($sformatf("row%0d sim_done", i), 32'(sim_done), 32'(vq[i].e_done));
      chk($sformatf("row%0d tx_overflow", i), 32'(tx_overflow), 32'(vq[i].e_ovf));
    end

    // Randomized traffic against the model
    step(1, 0, IDLE, 8'h00, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) step(0, 1, 32'h100 + 32'(k), 8'($urandom), 0, 0, 8'h00);
    prev_addr = IDLE;
    prev_rw = 0;
    pct = 50;
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) pct = (c / 100 % 3 == 0) ? 10 : ((c / 100 % 3 == 1) ? 90 : 50);
      op = $urandom_range(0, 9);
      txr = $urandom_range(0, 99) < pct;
      case (op)
        0, 1, 2: addr = ($urandom & 32'hFFFC_0000) | (32'h100 + 32'($urandom_range(0, 7)));
        3, 4, 5, 6: addr = ($urandom & 32'hFFFD_FFF8) | 32'h0002_0000;
        7: addr = ST;
        8: addr = 32'h0002_0000 | 32'(3'($urandom_range(0, 2) * 2 + 1));
        default: addr = prev_rw ? ST : prev_addr;
      endcase
      if (op == 9 && !prev_rw) prev_rw = 0;
      else prev_rw = (op == 0 || op == 3 || op == 4 || op == 8) ? 1'b1 : 1'b0;
      step(0, prev_rw, addr, 8'($urandom), txr, $urandom_range(0, 1) == 1, 8'($urandom));
      prev_addr = addr;
    end

    // Ordered stream through TX pointer wrap-around
    step(1, 0, IDLE, 8'h00, 0, 0, 8'h00);
    cyc = 0;
    while ((out_q.size() < 3 * D) && (cyc < 3000)) begin
      txr = $urandom_range(0, 1) == 1;
      if (io_tx_valid && txr) out_q.push_back(io_tx_data);
      if (in_q.size() < 3 * D && txq.size() < D) begin
        addr = 8'($urandom);
        in_q.push_back(addr[7:0]);
        step(0, 1, D0, addr[7:0], txr, 0, 8'h00);
      end else begin
        step(0, 0, IDLE, 8'h00, txr, 0, 8'h00);
      end
      cyc++;
    end
    chk("stream length", 32'(out_q.size()), 32'(3 * D));
    foreach (out_q[i]) chk($sformatf("stream byte %0d", i), 32'(out_q[i]), 32'(in_q[i]));
    chk("stream no overflow", 32'(tx_overflow), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
